vinsn_scoreboard: RTL and testbench

- Hazard-tracking issue scheduler between `vinsn_decoder` and `vinsn_launcher`.
- Records the destination register of every in-flight vector instruction, indexed by insn_id.
- Holds back a new instruction while it has a RAW or WAW hazard on an in-flight vd, or while its insn_id is still in use.
- Releases entries on commit-controller done pulses; forwards cleared instructions through a one-deep registered output stage.

---
 rtl/vinsn_scoreboard_if.sv | 41 ++++
 rtl/vinsn_scoreboard.sv | 118 +++++++++++
 tb/tb_vinsn_scoreboard.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vinsn_scoreboard_if.sv
// Decoder-side instruction channel, launcher-side issue channel and commit
// retire channel of the vector instruction scoreboard.
interface vinsn_scoreboard_if #(
  parameter int NrVReg    = 32,
  parameter int InsnIDNum = 8
);
  localparam int RegW = $clog2(NrVReg);
  localparam int IdW  = $clog2(InsnIDNum);

  logic            in_valid_i;
  logic            in_ready_o;
  logic [RegW-1:0] in_vd_i;
  logic [RegW-1:0] in_vs1_i;
  logic [RegW-1:0] in_vs2_i;
  logic            in_use_vs1_i;
  logic            in_use_vs2_i;
  logic            in_wr_vd_i;
  logic [IdW-1:0]  in_id_i;

  logic            out_valid_o;
  logic            out_ready_i;
  logic [RegW-1:0] out_vd_o;
  logic [RegW-1:0] out_vs1_o;
  logic [RegW-1:0] out_vs2_o;
  logic [IdW-1:0]  out_id_o;

  logic            done_i;
  logic [IdW-1:0]  done_id_i;

  modport slave (
    input  in_valid_i, in_vd_i, in_vs1_i, in_vs2_i, in_use_vs1_i, in_use_vs2_i,
    input  in_wr_vd_i, in_id_i, out_ready_i, done_i, done_id_i,
    output in_ready_o, out_valid_o, out_vd_o, out_vs1_o, out_vs2_o, out_id_o
  );

  modport master (
    output in_valid_i, in_vd_i, in_vs1_i, in_vs2_i, in_use_vs1_i, in_use_vs2_i,
    output in_wr_vd_i, in_id_i, out_ready_i, done_i, done_id_i,
    input  in_ready_o, out_valid_o, out_vd_o, out_vs1_o, out_vs2_o, out_id_o
  );
endinterface

// File: rtl/vinsn_scoreboard.sv
// Vector instruction scoreboard: blocks RAW/WAW hazards and insn_id reuse
// against in-flight instructions, forwards cleared ones through one register.
module vinsn_scoreboard #(
  parameter  int NrVReg    = 32,
  parameter  int InsnIDNum = 8,
  parameter  int StallCntW = 16,
  localparam int RegW      = $clog2(NrVReg),
  localparam int IdW       = $clog2(InsnIDNum)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  vinsn_scoreboard_if.slave    sb,
  output logic [IdW:0]         outstanding_o,
  output logic                 release_err_o,
  output logic [StallCntW-1:0] stall_cnt_o
);

  function automatic logic [StallCntW-1:0] sat_inc(input logic [StallCntW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic [IdW:0] popcount(input logic [InsnIDNum-1:0] v);
    logic [IdW:0] cnt;
    cnt = '0;
    for (int i = 0; i < InsnIDNum; i++) cnt = cnt + (IdW+1)'(v[i]);
    return cnt;
  endfunction

  logic [InsnIDNum-1:0] busy_q, busy_d;
  logic [InsnIDNum-1:0] valid_q, valid_d;
  logic [RegW-1:0]      vd_q [InsnIDNum];
  logic                 raw, waw, id_busy, slot_free, accept, release_ok;
  logic                 vld_p1;
  logic [RegW-1:0]      out_vd_p1, out_vs1_p1, out_vs2_p1;
  logic [IdW-1:0]       out_id_p1;
  logic [IdW:0]         outstanding_q;
  logic                 release_err_q;
  logic [StallCntW-1:0] stall_cnt_q;

  // Hazard detection against pre-release state (no done bypass)
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int e = 0; e < InsnIDNum; e++) begin
      if (valid_q[e]) begin
        if ((sb.in_use_vs1_i && vd_q[e] == sb.in_vs1_i) ||
            (sb.in_use_vs2_i && vd_q[e] == sb.in_vs2_i)) raw = 1'b1;
        if (sb.in_wr_vd_i && vd_q[e] == sb.in_vd_i) waw = 1'b1;
      end
    end
  end

  assign id_busy       = busy_q[sb.in_id_i];
  assign slot_free     = !vld_p1 || sb.out_ready_i;
  assign sb.in_ready_o = slot_free && !raw && !waw && !id_busy;
  assign accept        = sb.in_valid_i && sb.in_ready_o;
  assign release_ok    = sb.done_i && busy_q[sb.done_id_i];

  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    if (release_ok) begin
      busy_d[sb.done_id_i]  = 1'b0;
      valid_d[sb.done_id_i] = 1'b0;
    end
    if (accept) begin
      busy_d[sb.in_id_i]  = 1'b1;
      valid_d[sb.in_id_i] = sb.in_wr_vd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q        <= '0;
      valid_q       <= '0;
      outstanding_q <= '0;
      release_err_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      outstanding_q <= popcount(busy_d);
      release_err_q <= sb.done_i && !busy_q[sb.done_id_i];
      if (sb.in_valid_i && slot_free && (raw || waw || id_busy))
        stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && sb.in_wr_vd_i) vd_q[sb.in_id_i] <= sb.in_vd_i;
  end

  // Stage p1: registered issue slot towards the launcher
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     vld_p1 <= 1'b0;
    else if (accept)                 vld_p1 <= 1'b1;
    else if (vld_p1 && sb.out_ready_i) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      out_vd_p1  <= sb.in_vd_i;
      out_vs1_p1 <= sb.in_vs1_i;
      out_vs2_p1 <= sb.in_vs2_i;
      out_id_p1  <= sb.in_id_i;
    end
  end

  assign sb.out_valid_o = vld_p1;
  assign sb.out_vd_o    = out_vd_p1;
  assign sb.out_vs1_o   = out_vs1_p1;
  assign sb.out_vs2_o   = out_vs2_p1;
  assign sb.out_id_o    = out_id_p1;
  assign outstanding_o  = outstanding_q;
  assign release_err_o  = release_err_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_vinsn_scoreboard.sv
// Scoreboard bench for vinsn_scoreboard: directed hazard scenarios followed by
// randomized traffic, all checked against an id/register-set reference model.
module tb_vinsn_scoreboard;
  localparam int NrVReg = 32, InsnIDNum = 8, StallCntW = 16;
  localparam int IdW = $clog2(InsnIDNum);
  localparam int StallMax = (1 << StallCntW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IdW:0] outstanding;
  logic release_err;
  logic [StallCntW-1:0] stall_cnt;

  always #5 clk = ~clk;

  vinsn_scoreboard_if #(.NrVReg(NrVReg), .InsnIDNum(InsnIDNum)) sb_if ();

  vinsn_scoreboard #(.NrVReg(NrVReg), .InsnIDNum(InsnIDNum), .StallCntW(StallCntW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sb(sb_if.slave),
    .outstanding_o(outstanding), .release_err_o(release_err), .stall_cnt_o(stall_cnt)
  );

  typedef struct { int vd; int vs1; int vs2; int id; } exp_t;

  int   n_checks = 0, n_fail = 0;
  exp_t exp_q[$];
  bit   busy_m[int];
  int   wr_vd_m[int];
  bit   exp_ovld = 0, exp_err = 0;
  int   stall_m = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // True when the presented instruction must wait for an in-flight one.
  function automatic bit model_blocked();
    int v;
    if (busy_m.exists(int'(sb_if.in_id_i))) return 1'b1;
    foreach (wr_vd_m[k]) begin
      v = wr_vd_m[k];
      if (sb_if.in_use_vs1_i && v == int'(sb_if.in_vs1_i)) return 1'b1;
      if (sb_if.in_use_vs2_i && v == int'(sb_if.in_vs2_i)) return 1'b1;
      if (sb_if.in_wr_vd_i && v == int'(sb_if.in_vd_i)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference model: checks every cycle, then advances its own state.
  always @(negedge clk) begin
    bit slot_free, exp_ready, acc, err_next;
    exp_t e;
    if (!rst_n) begin
      check("rst_out_valid", int'(sb_if.out_valid_o), 0);
      check("rst_outstanding", int'(outstanding), 0);
      check("rst_release_err", int'(release_err), 0);
      check("rst_stall_cnt", int'(stall_cnt), 0);
      busy_m.delete(); wr_vd_m.delete(); exp_q.delete();
      exp_ovld = 0; exp_err = 0; stall_m = 0;
    end else begin
      slot_free = !exp_ovld || sb_if.out_ready_i;
      exp_ready = slot_free && !model_blocked();
      check("in_ready", int'(sb_if.in_ready_o), int'(exp_ready));
      check("out_valid", int'(sb_if.out_valid_o), int'(exp_ovld));
      check("outstanding", int'(outstanding), busy_m.num());
      check("release_err", int'(release_err), int'(exp_err));
      check("stall_cnt", int'(stall_cnt), stall_m);
      acc = sb_if.in_valid_i && exp_ready;
      err_next = sb_if.done_i && !busy_m.exists(int'(sb_if.done_id_i));
      if (sb_if.in_valid_i && slot_free && !exp_ready && stall_m < StallMax) stall_m++;
      if (sb_if.done_i && !err_next) begin
        busy_m.delete(int'(sb_if.done_id_i));
        wr_vd_m.delete(int'(sb_if.done_id_i));
      end
      if (acc) begin
        busy_m[int'(sb_if.in_id_i)] = 1'b1;
        if (sb_if.in_wr_vd_i) wr_vd_m[int'(sb_if.in_id_i)] = int'(sb_if.in_vd_i);
        e.vd = int'(sb_if.in_vd_i); e.vs1 = int'(sb_if.in_vs1_i);
        e.vs2 = int'(sb_if.in_vs2_i); e.id = int'(sb_if.in_id_i);
        exp_q.push_back(e);
      end
      if (acc) exp_ovld = 1'b1;
      else if (sb_if.out_ready_i) exp_ovld = 1'b0;
      exp_err = err_next;
    end
  end

  // Output monitor: every transfer to the launcher pops one expected payload.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb_if.out_valid_o && sb_if.out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_vd", int'(sb_if.out_vd_o), e.vd);
        check("out_vs1", int'(sb_if.out_vs1_o), e.vs1);
        check("out_vs2", int'(sb_if.out_vs2_o), e.vs2);
        check("out_id", int'(sb_if.out_id_o), e.id);
      end
    end
  end

  task automatic drive(input bit v, input int id, input int vd, input int vs1, input int vs2,
                       input bit u1, input bit u2, input bit wr, input bit ordy,
                       input bit dn, input int did);
    sb_if.in_valid_i   = v;
    sb_if.in_id_i      = IdW'(id);
    sb_if.in_vd_i      = 5'(vd);
    sb_if.in_vs1_i     = 5'(vs1);
    sb_if.in_vs2_i     = 5'(vs2);
    sb_if.in_use_vs1_i = u1;
    sb_if.in_use_vs2_i = u2;
    sb_if.in_wr_vd_i   = wr;
    sb_if.out_ready_i  = ordy;
    sb_if.done_i       = dn;
    sb_if.done_id_i    = IdW'(did);
  endtask

  task automatic idle(input bit ordy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, ordy, 0, 0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int pick_busy_id();
    int n, k;
    n = $urandom_range(0, busy_m.num() - 1);
    k = 0;
    foreach (busy_m[id]) begin
      if (k == n) return id;
      k++;
    end
    return 0;
  endfunction

  initial begin
    int base;
    idle(1);
    repeat (2) step();
    rst_n = 1'b1;

    // Basic issue: id0 writes v3
    drive(1, 0, 3, 0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk); check("t1_ready", int'(sb_if.in_ready_o), 1);
    step(); idle(1);
    @(negedge clk);
    check("t1_out_valid", int'(sb_if.out_valid_o), 1);
    check("t1_out_vd", int'(sb_if.out_vd_o), 3);
    check("t1_out_id", int'(sb_if.out_id_o), 0);
    check("t1_outstanding", int'(outstanding), 1);

    // RAW on v3: stalled four cycles plus the cycle of the done pulse
    base = stall_m;
    step(); drive(1, 1, 9, 3, 0, 1, 0, 0, 1, 0, 0);
    repeat (4) begin
      @(negedge clk); check("raw_ready", int'(sb_if.in_ready_o), 0);
      step();
    end
    drive(1, 1, 9, 3, 0, 1, 0, 0, 1, 1, 0);
    @(negedge clk); check("raw_ready_done_cycle", int'(sb_if.in_ready_o), 0);
    step(); drive(1, 1, 9, 3, 0, 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("raw_ready_after_done", int'(sb_if.in_ready_o), 1);
    check("raw_stall_cnt", int'(stall_cnt), base + 5);
    step();

    // WAW on v5
    drive(1, 2, 5, 0, 0, 0, 0, 1, 1, 0, 0); step();
    drive(1, 3, 5, 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (3) begin
      @(negedge clk); check("waw_ready", int'(sb_if.in_ready_o), 0);
      step();
    end
    drive(1, 3, 5, 0, 0, 0, 0, 1, 1, 1, 2);
    @(negedge clk); check("waw_ready_done_cycle", int'(sb_if.in_ready_o), 0);
    step(); drive(1, 3, 5, 0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk); check("waw_ready_after_done", int'(sb_if.in_ready_o), 1);
    step(); drive(1, 4, 6, 0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk); check("waw_independent_ready", int'(sb_if.in_ready_o), 1);
    step();

    // Id reuse: id1 still in flight without a vd
    drive(1, 1, 12, 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (3) begin
      @(negedge clk); check("idreuse_ready", int'(sb_if.in_ready_o), 0);
      step();
    end
    drive(1, 1, 12, 0, 0, 0, 0, 1, 1, 1, 1); step();
    drive(1, 1, 12, 0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk); check("idreuse_ready_after_done", int'(sb_if.in_ready_o), 1);
    step();

    // Backpressure: payload held, then back-to-back transfer
    idle(1); step();
    drive(1, 5, 7, 1, 2, 0, 0, 1, 0, 0, 0); step();
    drive(1, 6, 8, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (5) begin
      @(negedge clk);
      check("bp_ready", int'(sb_if.in_ready_o), 0);
      check("bp_hold_vd", int'(sb_if.out_vd_o), 7);
      check("bp_hold_id", int'(sb_if.out_id_o), 5);
      step();
    end
    drive(1, 6, 8, 0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk); check("bp_release_ready", int'(sb_if.in_ready_o), 1);
    step(); idle(1);
    @(negedge clk);
    check("bp_b2b_valid", int'(sb_if.out_valid_o), 1);
    check("bp_b2b_id", int'(sb_if.out_id_o), 6);
    step();

    // Spurious done on id7
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7); step(); idle(1);
    @(negedge clk);
    check("spurious_err_high", int'(release_err), 1);
    check("spurious_outstanding", int'(outstanding), 5);
    step();
    @(negedge clk); check("spurious_err_low", int'(release_err), 0);

    // Stall counter saturation: RAW on v7 (held by id5) for 70000 cycles
    drive(1, 0, 0, 0, 7, 0, 1, 0, 1, 0, 0);
    repeat (70000) step();
    @(negedge clk);
    check("sat_stall_cnt", int'(stall_cnt), StallMax);
    check("sat_ready", int'(sb_if.in_ready_o), 0);
    step();

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, InsnIDNum - 1),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            (busy_m.num() > 0 && $urandom_range(0, 4) != 0) ? pick_busy_id()
                                                           : $urandom_range(0, InsnIDNum - 1));
      step();
    end

    idle(1);
    repeat (3) step();
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
